mem_responder: RTL

Word-addressed memory that answers the multicycle controller's MemRead/MemWrite strobes, the responding end of the controller's memory interface. It samples a request, inserts a programmable number of wait states, performs the access, and returns a one-cycle `mem_ready` pulse with registered read data. It sits between the datapath's address/write-data path (selected by IorD) and the instruction/data registers, replacing the zero-latency behavioural memory.

---
 rtl/mem_resp_pkg.sv | 9 +
 rtl/mem_resp_array.sv | 37 +++
 rtl/mem_responder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types for mem_responder: FSM states, operation encoding, wait-counter width.
package mem_resp_pkg;

  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x DATA_W word storage: one synchronous write port, one synchronous read port
// whose output register holds its value until the next read.
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately not reset; only the read register is.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder for the multicycle controller's MemRead/MemWrite strobes.
// Define MEM_RESP_ERR_CHECK_EN to flag misaligned, out-of-range and dual-strobe requests.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              mem_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WaitInit = WAIT_CYCLES[WAIT_W-1:0];
  localparam logic [WAIT_W-1:0] CntOne   = WAIT_W'(1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  op_e                 op_q;
  logic                err_q;
  logic [AW-1:0]       idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ready_q, merr_q;

  logic                req;
  op_e                 req_op;
  logic                req_err;
  op_e                 acc_op;
  logic                acc_err;
  logic [AW-1:0]       acc_idx;
  logic [DATA_W-1:0]   acc_wdata;
  logic                enter_resp, arr_we, arr_re;

  assign req    = mem_read | mem_write;
  assign req_op = mem_write ? OP_WR : OP_RD;

`ifdef MEM_RESP_ERR_CHECK_EN
  assign req_err = (mem_read & mem_write) | (addr[1:0] != 2'b00) | (addr[31:AW+2] != '0);
`else
  logic unused_addr;
  assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign req_err     = 1'b0;
`endif

  // With zero wait states the access happens on the capture edge, so use live inputs there.
  always_comb begin
    if (state_q == IDLE) begin
      acc_op    = req_op;
      acc_err   = req_err;
      acc_idx   = addr[AW+1:2];
      acc_wdata = wdata;
    end else begin
      acc_op    = op_q;
      acc_err   = err_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d   = WaitInit;
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign arr_we     = enter_resp && (acc_op == OP_WR) && !acc_err;
  assign arr_re     = enter_resp && (acc_op == OP_RD) && !acc_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_RD;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= enter_resp;
      merr_q  <= enter_resp & acc_err;
      if (state_q == IDLE && req) begin
        op_q    <= req_op;
        err_q   <= req_err;
        idx_q   <= addr[AW+1:2];
        wdata_q <= wdata;
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_err   = merr_q;

  mem_resp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (arr_we),
    .waddr (acc_idx),
    .wdata (acc_wdata),
    .re    (arr_re),
    .raddr (acc_idx),
    .rdata (rdata)
  );

endmodule
